// File: rtl/srl_pkg.sv
// Shared definitions for the addressable shift-register family.
//   SRL_MAX_DEPTH / SRL_MAX_WIDTH : upper bounds on the DEPTH and WIDTH parameters
//   srl_clog2                     : address width for a given stage count
//   srl_fill_t                    : wide enough for a fill count of SRL_MAX_DEPTH
package srl_pkg;

  localparam int SRL_MAX_DEPTH = 256;
  localparam int SRL_MAX_WIDTH = 64;

  function automatic int srl_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  typedef logic [srl_clog2(SRL_MAX_DEPTH):0] srl_fill_t;

endpackage

// File: rtl/srl_fill_ctr.sv
// Saturating fill counter and tap-valid compare.
//   clk     : clock; the active edge is chosen by IS_CLK_INVERTED
//   rst     : synchronous reset, active-high, clears the count
//   ce      : one stage written on this edge
//   addr    : read tap address
//   fill    : stages written since reset, saturating at DEPTH
//   qv_comb : addr < fill, combinational
module srl_fill_ctr
  import srl_pkg::*;
#(
  parameter int DEPTH           = 32,
  parameter int IS_CLK_INVERTED = 0,
  parameter int AW              = srl_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [AW-1:0] addr,
  output logic [AW:0]   fill,
  output logic          qv_comb
);

  logic [AW:0] fill_q;
  logic [AW:0] fill_nxt;

  // The count stops at DEPTH rather than wrapping.
  always_comb begin
    fill_nxt = fill_q;
    if (ce && (fill_q != (AW+1)'(DEPTH))) fill_nxt = fill_q + 1'b1;
  end

  generate
    if (IS_CLK_INVERTED != 0) begin : g_neg
      always_ff @(negedge clk) begin
        if (rst) fill_q <= '0;
        else     fill_q <= fill_nxt;
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        if (rst) fill_q <= '0;
        else     fill_q <= fill_nxt;
      end
    end
  endgenerate

  assign fill    = fill_q;
  assign qv_comb = srl_fill_t'(addr) < srl_fill_t'(fill_q);

endmodule

// File: rtl/srl_dyn_shift_multi.sv
// Multi-channel addressable shift register (variable delay line / history buffer).
//   CLK  : clock; active edge is negedge when IS_CLK_INVERTED=1, else posedge
//   R    : synchronous reset, active-high; reloads INIT and clears FILL
//   CE   : shift enable; D enters stage 0, stage DEPTH-1 is dropped
//   D    : WIDTH-bit word shifted in
//   A    : read tap, 0 = newest stage
//   Q    : stage[A], combinational or registered (REG_OUT)
//   QCAS : stage[DEPTH-1], always combinational, for cascading
//   FILL : stages written since reset, saturating at DEPTH
//   QV   : A < FILL, timed like Q
module srl_dyn_shift_multi
  import srl_pkg::*;
#(
  parameter int                          WIDTH           = 8,
  parameter int                          DEPTH           = 32,
  parameter logic [WIDTH*DEPTH-1:0]      INIT            = '0,
  parameter int                          IS_CLK_INVERTED = 0,
  parameter int                          REG_OUT         = 0,
  localparam int                         AW              = srl_clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QCAS,
  output logic [AW:0]      FILL,
  output logic             QV
);

  logic [WIDTH-1:0] stage_q    [DEPTH];
  logic [WIDTH-1:0] stage_nxt  [DEPTH];
  logic [WIDTH-1:0] stage_init [DEPTH];
  logic [WIDTH-1:0] tap_p0;
  logic             vld_p0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_init
    assign stage_init[k] = INIT[k*WIDTH +: WIDTH];
  end

  always_comb begin
    stage_nxt = stage_q;
    if (CE) begin
      stage_nxt[0] = D;
      for (int k = 1; k < DEPTH; k++) stage_nxt[k] = stage_q[k-1];
    end
  end

  // Stage storage: reset reloads INIT and wins over a shift on the same edge.
  generate
    if (IS_CLK_INVERTED != 0) begin : g_store_neg
      always_ff @(negedge CLK) begin
        if (R) stage_q <= stage_init;
        else   stage_q <= stage_nxt;
      end
    end else begin : g_store_pos
      always_ff @(posedge CLK) begin
        if (R) stage_q <= stage_init;
        else   stage_q <= stage_nxt;
      end
    end
  endgenerate

  srl_fill_ctr #(
    .DEPTH           (DEPTH),
    .IS_CLK_INVERTED (IS_CLK_INVERTED),
    .AW              (AW)
  ) u_fill (
    .clk     (CLK),
    .rst     (R),
    .ce      (CE),
    .addr    (A),
    .fill    (FILL),
    .qv_comb (vld_p0)
  );

  assign tap_p0 = stage_q[A];
  assign QCAS   = stage_q[DEPTH-1];

  // Output stage p0 -> p1: optional register, loaded every edge regardless of CE.
  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] q_p1;
      logic             vld_p1;
      if (IS_CLK_INVERTED != 0) begin : g_neg
        always_ff @(negedge CLK) begin
          if (R) begin
            q_p1   <= '0;
            vld_p1 <= 1'b0;
          end else begin
            q_p1   <= tap_p0;
            vld_p1 <= vld_p0;
          end
        end
      end else begin : g_pos
        always_ff @(posedge CLK) begin
          if (R) begin
            q_p1   <= '0;
            vld_p1 <= 1'b0;
          end else begin
            q_p1   <= tap_p0;
            vld_p1 <= vld_p0;
          end
        end
      end
      assign Q  = q_p1;
      assign QV = vld_p1;
    end else begin : g_comb_out
      assign Q  = tap_p0;
      assign QV = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_srl_dyn_shift_multi.sv
module tb_srl_dyn_shift_multi;

  localparam int W  = 8;
  localparam int DP = 32;
  localparam int AW = 5;

  function automatic logic [W*DP-1:0] make_ramp();
    logic [W*DP-1:0] v;
    v = '0;
    for (int k = 0; k < DP; k++) v[k*W +: W] = 8'(k);
    return v;
  endfunction

  localparam logic [W*DP-1:0] INIT_RAMP = make_ramp();

  logic          clk = 1'b0;
  logic          r   = 1'b1;
  logic          ce  = 1'b0;
  logic [W-1:0]  d   = '0;
  logic [AW-1:0] a   = '0;

  logic [W-1:0]  q    [4];
  logic [W-1:0]  qcas [4];
  logic [AW:0]   fill [4];
  logic          qv   [4];

  always #5 clk = ~clk;

  // u0: plain, INIT=0; u1: ramp INIT; u2: ramp INIT + registered output; u3: negedge clock
  srl_dyn_shift_multi #(.WIDTH(W), .DEPTH(DP), .INIT('0), .IS_CLK_INVERTED(0), .REG_OUT(0)) u0 (
    .CLK(clk), .R(r), .CE(ce), .D(d), .A(a), .Q(q[0]), .QCAS(qcas[0]), .FILL(fill[0]), .QV(qv[0]));
  srl_dyn_shift_multi #(.WIDTH(W), .DEPTH(DP), .INIT(INIT_RAMP), .IS_CLK_INVERTED(0), .REG_OUT(0)) u1 (
    .CLK(clk), .R(r), .CE(ce), .D(d), .A(a), .Q(q[1]), .QCAS(qcas[1]), .FILL(fill[1]), .QV(qv[1]));
  srl_dyn_shift_multi #(.WIDTH(W), .DEPTH(DP), .INIT(INIT_RAMP), .IS_CLK_INVERTED(0), .REG_OUT(1)) u2 (
    .CLK(clk), .R(r), .CE(ce), .D(d), .A(a), .Q(q[2]), .QCAS(qcas[2]), .FILL(fill[2]), .QV(qv[2]));
  srl_dyn_shift_multi #(.WIDTH(W), .DEPTH(DP), .INIT('0), .IS_CLK_INVERTED(1), .REG_OUT(0)) u3 (
    .CLK(clk), .R(r), .CE(ce), .D(d), .A(a), .Q(q[3]), .QCAS(qcas[3]), .FILL(fill[3]), .QV(qv[3]));

  localparam int F_Q = 0, F_QV = 1, F_FILL = 2, F_QCAS = 3;

  typedef struct {
    int          dut;
    int          fld;
    string       name;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic logic [63:0] get_sig(input int dut, input int fld);
    case (fld)
      F_Q:     return 64'(q[dut]);
      F_QV:    return 64'(qv[dut]);
      F_FILL:  return 64'(fill[dut]);
      default: return 64'(qcas[dut]);
    endcase
  endfunction

  task automatic expect_val(input int dut, input int fld, input string name, input logic [63:0] v);
    sb_t e;
    e.dut = dut; e.fld = fld; e.name = name; e.exp = v;
    sb_q.push_back(e);
  endtask

  // Monitor: 2 time units after every clock transition, all queued expectations are compared.
  initial begin
    sb_t         e;
    logic [63:0] act;
    forever begin
      @(posedge clk or negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = get_sig(e.dut, e.fld);
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: actual=%0h required=%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic drive(input logic rv, input logic cev, input logic [W-1:0] dv, input logic [AW-1:0] av);
    r = rv; ce = cev; d = dv; a = av;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    drive(1, 0, 8'h00, 0);
    tick();
    expect_val(0, F_FILL, "rst_fill_u0", 0);
    expect_val(0, F_QV,   "rst_qv_u0",   0);
    expect_val(0, F_QCAS, "rst_qcas_u0", 0);
    expect_val(2, F_Q,    "rst_q_u2",    0);
    expect_val(2, F_QV,   "rst_qv_u2",   0);
    settle();

    // 1: five shifts 0x11..0x55
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 8'(i * 8'h11), 0);
      tick();
    end
    drive(0, 0, 8'h00, 0);
    expect_val(0, F_FILL, "t1_fill",   5);
    expect_val(0, F_Q,    "t1_q_a0",   8'h55);
    expect_val(0, F_QV,   "t1_qv_a0",  1);
    settle();
    drive(0, 0, 8'h00, 4);
    expect_val(0, F_Q,    "t1_q_a4",   8'h11);
    expect_val(0, F_QV,   "t1_qv_a4",  1);
    settle();
    drive(0, 0, 8'h00, 5);
    expect_val(0, F_Q,    "t1_q_a5",   8'h00);
    expect_val(0, F_QV,   "t1_qv_a5",  0);
    settle();

    // 2: saturation after 40 more shifts
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 8'(i), 0);
      tick();
    end
    drive(0, 0, 8'h00, 31);
    expect_val(0, F_FILL, "t2_fill_sat", 32);
    expect_val(0, F_QCAS, "t2_qcas",     8);
    expect_val(0, F_Q,    "t2_q_a31",    8);
    expect_val(0, F_QV,   "t2_qv_a31",   1);
    settle();
    drive(0, 0, 8'h00, 0);
    expect_val(0, F_Q,    "t2_q_a0",     39);
    settle();

    // 3: ramp INIT readable but not valid
    drive(1, 0, 8'h00, 7);
    tick();
    expect_val(1, F_Q,    "t3_init_q_a7",  7);
    expect_val(1, F_QV,   "t3_init_qv_a7", 0);
    expect_val(1, F_FILL, "t3_init_fill",  0);
    settle();
    drive(0, 1, 8'hAA, 0);
    tick();
    drive(0, 0, 8'h00, 0);
    expect_val(1, F_Q,    "t3_q_a0",  8'hAA);
    expect_val(1, F_QV,   "t3_qv_a0", 1);
    expect_val(1, F_FILL, "t3_fill",  1);
    settle();
    drive(0, 0, 8'h00, 8);
    expect_val(1, F_Q,    "t3_q_a8",  7);
    expect_val(1, F_QV,   "t3_qv_a8", 0);
    settle();

    // 4: registered output latency (u2: stage0=AA, stage1=0, FILL=1)
    drive(0, 0, 8'h00, 0);
    tick();
    drive(0, 1, 8'h3C, 0);
    tick();
    drive(0, 0, 8'h00, 0);
    expect_val(2, F_Q,    "t4_q_shift_edge", 8'hAA);
    expect_val(2, F_FILL, "t4_fill",         2);
    settle();
    tick();
    expect_val(2, F_QV, "t4_qv_after", 1);
    drive(0, 0, 8'h00, 1);
    expect_val(2, F_Q,  "t4_q_after",  8'h3C);
    settle();
    tick();
    expect_val(2, F_Q,  "t4_q_a1",     8'hAA);
    expect_val(2, F_QV, "t4_qv_a1",    1);
    drive(0, 0, 8'h00, 3);
    expect_val(2, F_Q,  "t4_q_a3_pre", 8'hAA);
    settle();
    tick();
    expect_val(2, F_Q,  "t4_q_a3",     1);
    expect_val(2, F_QV, "t4_qv_a3",    0);
    settle();

    // 5: reset with CE mid-stream at FILL=12
    drive(1, 0, 8'h00, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 8'(8'h40 + i), 0);
      tick();
    end
    drive(0, 0, 8'h00, 0);
    expect_val(2, F_FILL, "t5_fill12", 12);
    settle();
    drive(1, 1, 8'hFF, 0);
    tick();
    drive(0, 0, 8'h00, 0);
    expect_val(2, F_FILL, "t5_rst_fill_u2", 0);
    expect_val(2, F_Q,    "t5_rst_q_u2",    0);
    expect_val(2, F_QV,   "t5_rst_qv_u2",   0);
    expect_val(1, F_FILL, "t5_rst_fill_u1", 0);
    expect_val(1, F_Q,    "t5_noshift_u1",  0);
    settle();
    tick();
    expect_val(2, F_Q,    "t5_noshift_u2",  0);
    expect_val(2, F_QV,   "t5_qv_u2",       0);
    settle();
    drive(0, 0, 8'h00, 5);
    tick();
    expect_val(2, F_Q,    "t5_init_a5_u2",  5);
    expect_val(1, F_QCAS, "t5_qcas_u1",     8'h1F);
    settle();

    // 6: inverted clock; inputs live across a posedge, shift lands on the next negedge
    drive(1, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    drive(0, 0, 8'h00, 0);
    expect_val(3, F_FILL, "t6_rst_fill", 0);
    #2;
    drive(0, 1, 8'h5A, 0);
    expect_val(3, F_FILL, "t6_posedge_fill", 0);
    expect_val(3, F_Q,    "t6_posedge_q",    0);
    expect_val(3, F_QV,   "t6_posedge_qv",   0);
    @(posedge clk);
    #3;
    expect_val(3, F_FILL, "t6_negedge_fill", 1);
    expect_val(3, F_Q,    "t6_negedge_q",    8'h5A);
    expect_val(3, F_QV,   "t6_negedge_qv",   1);
    @(negedge clk);
    #1;
    drive(0, 0, 8'h00, 0);
    expect_val(3, F_FILL, "t6_hold_fill", 1);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clk);
    #3;
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
